// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bus between a requester and mem_responder.
//   Request channel : req_valid/req_ready handshake carrying req_we, req_addr
//                     (byte address), req_wdata and req_be (byte-lane enables).
//   Response channel: rsp_valid/rsp_ready handshake carrying rsp_rdata and rsp_err.
//   modport master : requester side (drives request, accepts response).
//   modport slave  : responder side (accepts request, drives response).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- single-outstanding word memory with a fixed response latency.
//   A request is accepted in IDLE, waits WAIT_STATES cycles, then the storage is
//   accessed on the edge entering RESP and the response is held until the
//   requester takes it. Writes honour byte enables; out-of-range word addresses
//   return an error without touching storage.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words of storage.
//   WAIT_STATES : extra cycles between acceptance and response (0..15).
// Ports:
//   clk   : clock, all state updates on its rising edge.
//   reset : synchronous active-high reset (storage contents are kept).
//   bus   : mem_responder_if.slave request/response channels.
// Optional feature:
//   MEM_ALIGN_CHECK_EN : when defined, a byte address with addr[1:0] != 0 is
//                        answered with an error and no write.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        req_rdy_p0;
  logic        req_we_p0;
  logic [31:0] req_addr_p0;
  logic [31:0] req_wdata_p0;
  logic [3:0]  req_be_p0;

  logic        rsp_vld_p1;
  logic [31:0] rsp_rdata_p1;
  logic        rsp_err_p1;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        go_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic        do_write;
  logic [AW-1:0] acc_idx;
  logic [31:0] rd_word;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // The zero-wait-state path accesses storage on the accept edge itself, so the
  // access view uses the live bus in IDLE and the captured request otherwise.
  always_comb begin
    accept    = (state == IDLE) && bus.req_valid;
    go_resp   = (WAIT_STATES == 0) ? accept : ((state == WAIT) && (cnt == 4'd1));
    acc_we    = (state == IDLE) ? bus.req_we    : req_we_p0;
    acc_addr  = (state == IDLE) ? bus.req_addr  : req_addr_p0;
    acc_wdata = (state == IDLE) ? bus.req_wdata : req_wdata_p0;
    acc_be    = (state == IDLE) ? bus.req_be    : req_be_p0;
    acc_err   = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
`ifdef MEM_ALIGN_CHECK_EN
    acc_err   = acc_err || (acc_addr[1:0] != 2'b00);
`endif
    acc_idx   = acc_addr[AW+1:2];
    rd_word   = mem[acc_idx];
    do_write  = go_resp && acc_we && !acc_err && !reset;
  end

`ifndef MEM_ALIGN_CHECK_EN
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_addr[1:0];
`endif

  // Stage p0: request capture, frozen after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p0    <= bus.req_we;
      req_addr_p0  <= bus.req_addr;
      req_wdata_p0 <= bus.req_wdata;
      req_be_p0    <= bus.req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[acc_idx] <= merge_bytes(rd_word, acc_wdata, acc_be);
  end

  // Stage p1: control FSM and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_rdy_p0   <= 1'b1;
      rsp_vld_p1   <= 1'b0;
      rsp_rdata_p1 <= 32'd0;
      rsp_err_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_rdy_p0 <= 1'b0;
            state      <= WAIT;
            cnt        <= 4'(WAIT_STATES);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state      <= IDLE;
            rsp_vld_p1 <= 1'b0;
            req_rdy_p0 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        state        <= RESP;
        cnt          <= 4'd0;
        rsp_vld_p1   <= 1'b1;
        rsp_err_p1   <= acc_err;
        rsp_rdata_p1 <= (acc_we || acc_err) ? 32'd0 : rd_word;
      end
    end
  end

  assign bus.req_ready = req_rdy_p0;
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign bus.rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [DEPTH];

  mem_responder_if bus();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: word-addressed array with mask-based byte merge.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] exp_d, output logic exp_e);
    int unsigned idx;
    logic [31:0] mask;
    logic bad;
    idx  = addr / 4;
    bad  = (idx >= DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
    bad  = bad || ((addr % 4) != 0);
`endif
    exp_d = 32'd0;
    exp_e = bad;
    if (!bad) begin
      if (we) begin
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
      end else begin
        exp_d = ref_mem[idx];
      end
    end
  endfunction

  task automatic drive_garbage(input logic v);
    bus.req_valid = v;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom & 32'h0000_03FF;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 64) begin @(negedge clk); t++; end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    @(negedge clk);
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    drive_garbage(1'b1);
    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      drive_garbage(1'b1);
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rdata);
      chk("hold_err", 32'(bus.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] rdata);
    logic [31:0] got, exp_d;
    logic err, exp_e;
    int lat;
    model(we, addr, wdata, be, exp_d, exp_e);
    xact(we, addr, wdata, be, hold, got, err, lat);
    chk("latency", 32'(lat), 32'(WS + 1));
    chk("rdata", got, exp_d);
    chk("err", 32'(err), 32'(exp_e));
    rdata = got;
  endtask

  initial begin
    logic [31:0] d, d_err_probe;
    logic e;
    int lat;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_be    = 4'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);

    for (int i = 0; i < DEPTH; i++) run(1'b1, 32'(i * 4), $urandom, 4'hF, 0, d);

    // Full write then read back with a fixed pattern.
    run(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, d);
    run(1'b0, 32'h10, 32'h0, 4'h0, 0, d);
    chk("rd_deadbeef", d, 32'hDEADBEEF);

    // Partial byte-lane write.
    run(1'b1, 32'h20, 32'h11223344, 4'hF, 0, d);
    run(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, d);
    run(1'b0, 32'h20, 32'h0, 4'hF, 0, d);
    chk("rd_partial", d, 32'h11BB33DD);

    // Zero byte enables leave the word alone; read ignores be.
    run(1'b1, 32'h20, 32'h55555555, 4'h0, 0, d);
    run(1'b0, 32'h20, 32'h0, 4'h2, 0, d);
    chk("rd_be0_noop", d, 32'h11BB33DD);

    // Backpressure: five cycles of rsp_ready low.
    run(1'b0, 32'h10, 32'h0, 4'hF, 5, d);
    chk("rd_backpressure", d, 32'hDEADBEEF);

    // Out of range.
    run(1'b0, 32'h400, 32'h0, 4'hF, 0, d);
    model(1'b0, 32'h0, 32'h0, 4'h0, d_err_probe, e);
    run(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, d);
    run(1'b0, 32'h0, 32'h0, 4'hF, 0, d);
    chk("word0_unchanged", d, d_err_probe);
    xact(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1, d, e, lat);
    chk("oor_high_err", 32'(e), 32'd1);
    chk("oor_high_rdata", d, 32'd0);

    // Unaligned address 0x13.
    run(1'b1, 32'h13, 32'h0BADC0DE, 4'hF, 0, d);
    run(1'b0, 32'h10, 32'h0, 4'hF, 0, d);
`ifdef MEM_ALIGN_CHECK_EN
    chk("unaligned_no_write", d, 32'hDEADBEEF);
`else
    chk("unaligned_word_write", d, 32'h0BADC0DE);
`endif

    // Reset during WAIT abandons the write (k=1 mid-wait, k=2 on the access edge).
    for (int k = 1; k <= 2; k++) begin
      run(1'b1, 32'h30, 32'h0, 4'hF, 0, d);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h30;
      bus.req_wdata = 32'hFFFFFFFF;
      bus.req_be    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (k - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_wait_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_wait_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_wait_err", 32'(bus.rsp_err), 32'd0);
      run(1'b0, 32'h30, 32'h0, 4'hF, 0, d);
      chk("rst_abandoned_write", d, 32'h0);
    end
    run(1'b0, 32'h10, 32'h0, 4'hF, 0, d);
    chk("storage_survives_reset", d, ref_mem[4]);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 32'h43F);
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      run(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 256, number of 32-bit words of storage.
REQ-002 SHALL have parameter: WAIT_STATES, 2, extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  requester presents a request.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port: req_wdata  input  32  write data.
REQ-010 SHALL have port: req_be  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-011 SHALL have port: rsp_valid  output  1  response available.
REQ-012 SHALL have port: rsp_ready  input  1  requester accepts the response.
REQ-013 SHALL have port: rsp_rdata  output  32  read data; 0 for writes and error responses.
REQ-014 SHALL have port: rsp_err  output  1  request failed; no storage change.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 IDLE: req_valid at posedge SHALL capture we/addr/wdata/be; go to WAIT with counter = WAIT_STATES, or directly to RESP when WAIT_STATES = 0.
REQ-017 WAIT: counter SHALL decrement each cycle; at the edge where counter = 1, go to RESP.
REQ-018 Storage access SHALL occur on the edge entering RESP; rsp_valid first high WAIT_STATES+1 cycles after the accept edge.
REQ-019 Write: SHALL update only enabled byte lanes of the addressed word; req_be = 0 is a legal no-op write with rsp_err = 0.
REQ-020 Read: rsp_rdata SHALL be the full addressed word regardless of req_be.
REQ-021 Out of range (req_addr[31:2] >= DEPTH_WORDS): rsp_err = 1, rsp_rdata = 0, no write.
REQ-022 RESP: rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_valid && rsp_ready at a posedge, then go to IDLE.
REQ-023 One outstanding request max; next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-024 Request inputs SHALL be ignored outside IDLE; captured values SHALL not change after acceptance.
REQ-025 Write-then-read of the same word SHALL return the written data (no stale read).

Reset
REQ-026 On reset: state = IDLE, counter = 0, req_ready = 1 from the next cycle, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-027 Reset SHALL override all other events at the same edge; an in-flight request SHALL be abandoned and its write not performed if not yet performed.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN defined: req_addr[1:0] != 0 SHALL give rsp_err = 1, rsp_rdata = 0, no write, same latency as a normal access.
REQ-030 MEM_ALIGN_CHECK_EN undefined: req_addr[1:0] SHALL be ignored; alignment never produces rsp_err.

Verification
REQ-031 WAIT_STATES=2: write addr 0x10, wdata 0xDEADBEEF, be 0xF; then read 0x10 -> rsp_valid 3 cycles after each accept; read rdata 0xDEADBEEF, err 0.
REQ-032 Partial write: word 0x20 = 0x11223344, then write 0xAABBCCDD be 0x5 -> read returns 0x11BB33DD.
REQ-033 Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid/rdata stable, req_ready = 0 throughout; accept on cycle 6 -> IDLE next cycle.
REQ-034 DEPTH_WORDS=256: read 0x400 -> err 1, rdata 0; write 0x400 then read word 0 -> word 0 unchanged.
REQ-035 Reset asserted in WAIT during write to 0x30 (old 0x0) -> rsp_valid 0, req_ready 1 after reset; read 0x30 returns 0x0.
REQ-036 Address 0x13: with MEM_ALIGN_CHECK_EN -> err 1, no write; without -> accesses word 0x10, err 0.
